// File: rtl/store_serializer.sv
// Store unit: narrows a 32-bit register value to 1/2/4 bytes and
// issues them little-endian, one beat per handshake, on an 8-bit port.
module store_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nx;
    logic [31:0] r_addr;
    logic [31:0] w_addr_nx;
    logic [31:0] r_data;
    logic [31:0] w_data_nx;
    logic        r_done;
    logic        w_done_nx;
    logic        r_err;
    logic        w_err_nx;
    logic        w_legal;
    logic [1:0]  w_last;

    // r_cnt holds beats remaining after the current one
    always_comb begin
        w_legal = 1'b0;
        w_last  = 2'd0;
        case (size)
            2'b00: begin
                w_legal = 1'b1;
                w_last  = 2'd0;
            end
            2'b01: begin
                w_legal = ~addr[0];
                w_last  = 2'd1;
            end
            2'b10: begin
                w_legal = (addr[1:0] == 2'b00);
                w_last  = 2'd3;
            end
            default: begin
                w_legal = 1'b0;
                w_last  = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_addr_nx  = r_addr;
        w_data_nx  = r_data;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_legal) begin
                        w_state_nx = SEND;
                        w_cnt_nx   = w_last;
                        w_addr_nx  = addr;
                        w_data_nx  = wdata;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
            end
            SEND: begin
                if (mem_ready) begin
                    if (r_cnt == 2'd0) begin
                        w_state_nx = IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_cnt_nx  = r_cnt - 2'd1;
                        w_addr_nx = r_addr + 32'd1;
                        w_data_nx = {8'h00, r_data[31:8]};
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_addr  <= w_addr_nx;
            r_data  <= w_data_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
        end
    end

    assign busy      = (r_state == SEND);
    assign mem_we    = (r_state == SEND);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_data[7:0];
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_store_serializer.sv
// Directed and randomized checks of store_serializer against a
// beat-list model built from the store size, address and data.
module tb_store_serializer;

    logic        clk;
    logic        rst;
    logic        req;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;

    int nvec;
    int nerr;

    store_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".we"}, 32'(mem_we), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".err"}, 32'(err), 32'd0);
        check({tag, ".we"}, 32'(mem_we), 32'd0);
        check({tag, ".addr"}, mem_addr, 32'd0);
        check({tag, ".wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_quiet("idle");
        end
    endtask

    // Issue one request at the current negedge; st packs per-beat stall
    // counts (2 bits each). Returns at the negedge where done is visible.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input logic [7:0] st);
        bit bad;
        int n;
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
              (sz == 2'b10 && a[1:0] != 2'b00);
        n = 1 << sz;
        req = 1'b1;
        size = sz;
        addr = a;
        wdata = d;
        mem_ready = 1'b1;
        @(negedge clk);
        req = 1'b0;
        size = 2'($urandom);
        addr = $urandom;
        wdata = $urandom;
        if (bad) begin
            check("err.pulse", 32'(err), 32'd1);
            check("err.busy", 32'(busy), 32'd0);
            check("err.we", 32'(mem_we), 32'd0);
            check("err.done", 32'(done), 32'd0);
            @(negedge clk);
            check("err.clear", 32'(err), 32'd0);
            check_quiet("err.after");
            return;
        end
        for (int b = 0; b < n; b++) begin
            int s;
            s = int'((st >> (2 * b)) & 8'h3);
            for (int w = 0; w <= s; w++) begin
                mem_ready = (w == s);
                check("beat.busy", 32'(busy), 32'd1);
                check("beat.we", 32'(mem_we), 32'd1);
                check("beat.addr", mem_addr, a + 32'(b));
                check("beat.data", 32'(mem_wdata), (d >> (8 * b)) & 32'hff);
                check("beat.done", 32'(done), 32'd0);
                check("beat.err", 32'(err), 32'd0);
                @(negedge clk);
            end
        end
        check("done.pulse", 32'(done), 32'd1);
        check("done.busy", 32'(busy), 32'd0);
        check("done.we", 32'(mem_we), 32'd0);
        check("done.err", 32'(err), 32'd0);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        req = 1'b0;
        size = 2'b00;
        addr = 32'd0;
        wdata = 32'd0;
        mem_ready = 1'b1;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // SB
        run_store(2'b00, 32'h0000_1003, 32'hAABB_CCDD, 8'h00);
        idle(1);
        check("sb.done_gone", 32'(done), 32'd0);

        // SW, 2nd beat stalled 2 cycles
        run_store(2'b10, 32'h0000_2000, 32'h1122_3344, 8'b00_00_10_00);
        idle(1);

        // Errors
        run_store(2'b01, 32'h0000_0001, 32'h1234_5678, 8'h00);
        run_store(2'b10, 32'h0000_0002, 32'h1234_5678, 8'h00);
        run_store(2'b11, 32'h0000_0000, 32'h1234_5678, 8'h00);
        idle(1);

        // Back-to-back: SB issued in the done cycle of SH
        run_store(2'b01, 32'h0000_3000, 32'h0000_BEEF, 8'h00);
        run_store(2'b00, 32'h0000_3002, 32'h0000_00A5, 8'h00);
        idle(1);

        // Async reset mid-cycle while a beat is held
        req = 1'b1;
        size = 2'b10;
        addr = 32'h0000_4000;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req = 1'b0;
        mem_ready = 1'b0;
        check("rst.pre_we", 32'(mem_we), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("rst.mid");
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        idle(3);

        // Abort during beat 2 of SW, then SB completes
        req = 1'b1;
        size = 2'b10;
        addr = 32'h0000_5000;
        wdata = 32'h8765_4321;
        @(negedge clk);
        req = 1'b0;
        check("abort.b0", 32'(mem_wdata), 32'h21);
        @(negedge clk);
        check("abort.b1", 32'(mem_wdata), 32'h43);
        rst = 1'b1;
        #1 check_all_zero("abort.rst");
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        run_store(2'b00, 32'h0000_6001, 32'h0000_0077, 8'h00);
        idle(1);

        // Randomized stores, stalls and gaps
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            logic [7:0]  st;
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            st = 8'h00;
            for (int b = 0; b < 4; b++)
                st = st | 8'(($urandom_range(0, 2)) << (2 * b));
            run_store(sz, a, $urandom, st);
            idle($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
